onehot_bin_accumulator: RTL and testbench
=========================================

# onehot_bin_accumulator

Downstream consumer of the registered 4-to-16 one-hot decoder in the bit-serial datapath. Each accepted beat adds a signed activation into every bin selected by the one-hot vector. After the group's last beat, the block drains the 16 bin sums one per cycle over a valid/ready handshake, then clears all bins for the next group.

## Interface
- ACT_W, 8, signed activation width
- ACC_W, 20, bin accumulator width (must be ≥ ACT_W)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_onehot  in  16  decoder output; bit 15 selects bin 0, bit 0 selects bin 15 (bin k ↔ in_onehot[15-k])
- in_act  in  ACT_W  signed activation for this beat
- in_valid  in  1  beat valid
- in_last  in  1  final beat of group; qualified by in_valid
- in_ready  out  1  high only in ACCUM
- out_data  out  ACC_W  signed bin sum
- out_idx  out  4  bin index of out_data
- out_valid  out  1  drain data valid
- out_last  out  1  high with out_idx == 15
- out_ready  in  1  downstream accept
- err_multi  out  1  sticky: a beat had more than one in_onehot bit set

## Operation
- Two states: ACCUM, DRAIN.
- ACCUM:
  - in_ready = 1.
  - A beat is accepted when in_valid && in_ready.
  - Each accepted beat adds sign-extended in_act to every bin k with in_onehot[15-k] = 1.
  - All-zero in_onehot: accepted, no bin changes, no error.
  - Multiple bits set: all selected bins update, and err_multi sets.
  - Accepting a beat with in_last = 1 moves to DRAIN at the same edge and clears the drain index to 0.
- DRAIN:
  - in_ready = 0.
  - out_valid = 1, out_data = bin[out_idx], out_last = (out_idx == 15).
  - Each out_valid && out_ready handshake increments out_idx.
  - The handshake at idx 15 clears all bins to 0 and returns to ACCUM.
  - out_data is held stable while out_ready = 0.
- Arithmetic: two's-complement, wraps modulo 2^ACC_W. No saturation, no overflow flag.
- err_multi clears only on reset.
- Reset (at any time, including mid-group or mid-drain):
  - state = ACCUM, all bins = 0, drain idx = 0, err_multi = 0.
  - Outputs: in_ready = 1, out_valid = 0, out_data = 0, out_idx = 0, out_last = 0.
  - Reset deassertion must be synchronised externally. The block releases on the first clk edge after reset goes high.

## Timing
- An accepted beat's contribution is visible in its bin one cycle after acceptance.
- The last beat's contribution is included in the drain. out_valid rises in the cycle immediately after the in_last beat is accepted.
- Drain takes exactly 16 handshakes; minimum 16 cycles with out_ready held high.
- in_ready returns high the cycle after the idx-15 handshake. Minimum group turnaround is 17 cycles after the last beat.
- Inputs arriving while in_ready = 0 are ignored, not buffered. The decoder feeding this block has no stall, so the controller must gate the decoder's input during DRAIN.
- out_* are driven from registers and ready/valid logic only, with no combinational path from in_* to out_*.
- There is no combinational path from out_ready to in_ready.

## Structure
- Shared package bitsim_acc_pkg holds:
  - typedef enum logic {ACCUM, DRAIN} acc_state_t
  - localparam NUM_BINS = 16
  - localparam IDX_W = 4
- Sub-module bin_acc_slice, instantiated 16×:
  - one ACC_W register
  - inputs: add_en, clear, sign-extended operand
  - async active-low reset
- The top level holds the FSM, drain index, output mux, and err_multi.

## Test plan
1. Reset, then 4 beats: onehot 16'h8000 with act +3, +5; onehot 16'h0001 with act −2, −2 (last). Drain with out_ready = 1 → out_valid rises the cycle after the last beat; idx0 = 8, idx15 = −4, all other bins 0; out_last high only on idx15; in_ready high exactly 16 cycles after out_valid rises.
2. Multi-bit beat: onehot 16'h8001, act 7, last → bin0 = 7, bin15 = 7, err_multi = 1 and stays 1 across the next group. A zero-onehot beat → no bin change, err unchanged.
3. Wrap: ACT_W = 8, ACC_W = 9, bin0 receives +127 ×3 (total 381) → drained value = 381 − 512 = −131.
4. Backpressure: during drain, out_ready toggles 1,0,0,1,… → out_idx and out_data hold on stalled cycles; no index is skipped or repeated; in_valid pulses during drain are ignored; the next group starts from all-zero bins.
5. Reset asserted at drain idx 6 → same cycle: out_valid = 0, in_ready = 1. After release, a 1-beat group with onehot 16'h0400 (bin 5), act −1 → bin5 = −1, all others 0.
6. Back-to-back groups: in_valid held high continuously with in_last every 3rd beat, out_ready = 1 → beats only accepted in ACCUM; each drain reflects only its own group's 3 beats.

Source files
------------

// File: rtl/bitsim_acc_pkg.sv
// -----------------------------------------------------------------------------
// bitsim_acc_pkg
// Shared definitions for the one-hot bin accumulator:
//   acc_state_t : controller state (ACCUM collects beats, DRAIN streams bins)
//   NUM_BINS    : number of accumulation bins (one per one-hot decoder line)
//   IDX_W       : width of a bin index
//   multi_hot() : true when more than one bit of a one-hot vector is set
// -----------------------------------------------------------------------------
package bitsim_acc_pkg;

  typedef enum logic {ACCUM, DRAIN} acc_state_t;

  localparam int NUM_BINS = 16;
  localparam int IDX_W    = 4;

  // Clearing the lowest set bit leaves something behind only when at least
  // two bits were set.
  function automatic logic multi_hot(input logic [NUM_BINS-1:0] v);
    logic [NUM_BINS-1:0] one;
    one = {{(NUM_BINS-1){1'b0}}, 1'b1};
    return (v & (v - one)) != '0;
  endfunction

endpackage

// File: rtl/bin_acc_slice.sv
// -----------------------------------------------------------------------------
// bin_acc_slice
// One accumulation bin: a single ACC_W-bit signed register that either clears
// or adds a pre-sign-extended operand. Clear has priority over add.
// Ports:
//   clk      in  clock, rising edge
//   reset    in  asynchronous active-low reset (register -> 0)
//   add_en   in  add operand into the bin this cycle
//   clear    in  force the bin to 0 this cycle
//   operand  in  ACC_W signed addend (already sign-extended)
//   sum      out ACC_W signed current bin value
// -----------------------------------------------------------------------------
module bin_acc_slice #(
  parameter int ACC_W = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    add_en,
  input  logic                    clear,
  input  logic signed [ACC_W-1:0] operand,
  output logic signed [ACC_W-1:0] sum
);

  logic signed [ACC_W-1:0] sum_d;
  logic signed [ACC_W-1:0] sum_q;

  // Addition wraps modulo 2^ACC_W by construction of the fixed-width adder.
  always_comb begin
    sum_d = sum_q;
    if (clear) begin
      sum_d = '0;
    end else if (add_en) begin
      sum_d = sum_q + operand;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/onehot_bin_accumulator.sv
// -----------------------------------------------------------------------------
// onehot_bin_accumulator
// Consumes beats from a registered 4-to-16 one-hot decoder. Every accepted
// beat adds its signed activation into each bin selected by the one-hot
// vector. After the beat flagged in_last, the 16 bin sums are streamed out
// one per handshake (bin 0 first), then all bins clear for the next group.
// Ports:
//   clk        in  clock, rising edge
//   reset      in  asynchronous active-low reset
//   in_onehot  in  [15:0] bin select; bin k <-> in_onehot[15-k]
//   in_act     in  [ACT_W-1:0] signed activation
//   in_valid   in  beat valid
//   in_last    in  final beat of the group (qualified by in_valid)
//   in_ready   out high only while accumulating
//   out_data   out [ACC_W-1:0] signed bin sum (0 when not draining)
//   out_idx    out [3:0] bin index of out_data
//   out_valid  out drain data valid
//   out_last   out high with the bin-15 beat of the drain
//   out_ready  in  downstream accept
//   err_multi  out sticky: some accepted beat had several one-hot bits set
// -----------------------------------------------------------------------------
module onehot_bin_accumulator
  import bitsim_acc_pkg::*;
#(
  parameter int ACT_W = 8,
  parameter int ACC_W = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_BINS-1:0]     in_onehot,
  input  logic signed [ACT_W-1:0] in_act,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_valid,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    err_multi
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BINS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  acc_state_t              state_d, state_q;
  logic [IDX_W-1:0]        idx_d, idx_q;
  logic                    err_multi_d, err_multi_q;

  logic                    accept;
  logic                    drain_hs;
  logic                    clear_all;
  logic [NUM_BINS-1:0]     add_en;
  logic signed [ACC_W-1:0] operand;
  logic signed [ACC_W-1:0] bin_sum [NUM_BINS];

  // Handshake qualifiers depend only on registered state, so there is no
  // combinational path from out_ready to in_ready or from in_* to out_*.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DRAIN);
  assign accept    = in_valid && in_ready;
  assign drain_hs  = out_valid && out_ready;
  assign clear_all = drain_hs && (idx_q == LAST_IDX);

  // Signed size cast sign-extends the activation to the bin width.
  assign operand = ACC_W'(in_act);

  // Controller next state: idx wraps 15 -> 0 on the final handshake, so it
  // already sits at 0 when the next group's drain begins.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    err_multi_d = err_multi_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (multi_hot(in_onehot)) begin
            err_multi_d = 1'b1;
          end
          if (in_last) begin
            state_d = DRAIN;
            idx_d   = '0;
          end
        end
      end
      DRAIN: begin
        if (drain_hs) begin
          idx_d = idx_q + IDX_ONE;
          if (idx_q == LAST_IDX) begin
            state_d = ACCUM;
          end
        end
      end
      default: begin
        state_d = ACCUM;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ACCUM;
      idx_q       <= '0;
      err_multi_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      err_multi_q <= err_multi_d;
    end
  end

  // Bin array: bin k listens to decoder line 15-k.
  for (genvar k = 0; k < NUM_BINS; k++) begin : g_bin
    assign add_en[k] = accept && in_onehot[NUM_BINS-1-k];

    bin_acc_slice #(
      .ACC_W(ACC_W)
    ) u_slice (
      .clk    (clk),
      .reset  (reset),
      .add_en (add_en[k]),
      .clear  (clear_all),
      .operand(operand),
      .sum    (bin_sum[k])
    );
  end

  // Output mux: bins are registers and idx is a register, so out_data is
  // naturally stable while out_ready stalls the drain.
  assign out_data  = out_valid ? bin_sum[idx_q] : '0;
  assign out_idx   = idx_q;
  assign out_last  = out_valid && (idx_q == LAST_IDX);
  assign err_multi = err_multi_q;

endmodule

// File: tb/tb_onehot_bin_accumulator.sv
module tb_onehot_bin_accumulator;

  localparam int ACT_W   = 8;
  localparam int ACC_W   = 20;
  localparam int W_ACC_W = 9;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Main DUT signals
  logic [15:0]             in_onehot;
  logic signed [ACT_W-1:0] in_act;
  logic                    in_valid;
  logic                    in_last;
  logic                    in_ready;
  logic signed [ACC_W-1:0] out_data;
  logic [3:0]              out_idx;
  logic                    out_valid;
  logic                    out_last;
  logic                    out_ready;
  logic                    err_multi;

  // Narrow-accumulator instance for the wrap test
  logic [15:0]               w_in_onehot;
  logic signed [ACT_W-1:0]   w_in_act;
  logic                      w_in_valid;
  logic                      w_in_last;
  logic                      w_in_ready;
  logic signed [W_ACC_W-1:0] w_out_data;
  logic [3:0]                w_out_idx;
  logic                      w_out_valid;
  logic                      w_out_last;
  logic                      w_out_ready;
  logic                      w_err_multi;

  onehot_bin_accumulator #(.ACT_W(ACT_W), .ACC_W(ACC_W)) u_dut (
    .clk(clk), .reset(reset),
    .in_onehot(in_onehot), .in_act(in_act), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready), .err_multi(err_multi)
  );

  onehot_bin_accumulator #(.ACT_W(ACT_W), .ACC_W(W_ACC_W)) u_wrap (
    .clk(clk), .reset(reset),
    .in_onehot(w_in_onehot), .in_act(w_in_act), .in_valid(w_in_valid),
    .in_last(w_in_last), .in_ready(w_in_ready),
    .out_data(w_out_data), .out_idx(w_out_idx), .out_valid(w_out_valid),
    .out_last(w_out_last), .out_ready(w_out_ready), .err_multi(w_err_multi)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int                      idx;
    logic signed [ACC_W-1:0] data;
  } exp_t;

  exp_t   exp_q[$];
  longint grp[16];       // reference sums of the group in progress
  logic   exp_err = 1'b0;
  int     ready_mode = 0; // 0: always ready, 1: 1,0,0 pattern, 2: random
  int     rdy_cnt = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: bins are plain integers indexed by bin number; a group
  // closes into 16 expected drain records, truncated to the bin width.
  task automatic model_accept(input logic [15:0] oh, input logic signed [ACT_W-1:0] act,
                              input logic last);
    logic [63:0] full;
    exp_t e;
    for (int k = 0; k < 16; k++)
      if (oh[15-k]) grp[k] += longint'(act);
    if ($countones(oh) > 1) exp_err = 1'b1;
    if (last) begin
      for (int k = 0; k < 16; k++) begin
        full   = grp[k];
        e.idx  = k;
        e.data = full[ACC_W-1:0];
        exp_q.push_back(e);
        grp[k] = 0;
      end
    end
  endtask

  // Monitor: compares every presented drain beat against the queue head and
  // pops only when the handshake will complete at the coming edge.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", out_valid, 0);
      end else begin
        check("out_idx", out_idx, exp_q[0].idx);
        check("out_data", out_data, exp_q[0].data);
        check("out_last", out_last, exp_q[0].idx == 15);
        check("in_ready_in_drain", in_ready, 0);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Downstream ready generator
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: begin out_ready = ((rdy_cnt % 3) == 0); rdy_cnt++; end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic send_beat(input logic [15:0] oh, input logic signed [ACT_W-1:0] act,
                           input logic last, input bit hold);
    logic rdy;
    rdy = 1'b0;
    in_onehot = oh; in_act = act; in_last = last; in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      #2;
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
    end
    if (!rdy) check("beat_accept_timeout", rdy, 1);
    else begin
      model_accept(oh, act, last);
      check("err_multi", err_multi, exp_err);
    end
    if (!hold) begin in_valid = 1'b0; in_last = 1'b0; end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin @(negedge clk); #2; t++; end
    check("drain_complete", exp_q.size(), 0);
    @(posedge clk);
    #1;
    check("in_ready_after_drain", in_ready, 1);
    check("out_valid_after_drain", out_valid, 0);
  endtask

  function automatic logic [15:0] rand_onehot();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 16'h0000;
    if (r == 1) return 16'($urandom);
    return 16'h0001 << $urandom_range(0, 15);
  endfunction

  task automatic rand_group(input int n);
    for (int i = 0; i < n; i++)
      send_beat(rand_onehot(), ACT_W'($urandom), (i == n - 1), 1'b0);
  endtask

  initial begin
    int n;
    for (int k = 0; k < 16; k++) grp[k] = 0;
    in_onehot = '0; in_act = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    w_in_onehot = '0; w_in_act = '0; w_in_valid = 1'b0; w_in_last = 1'b0; w_out_ready = 1'b1;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    // Reset state
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_err_multi", err_multi, 0);
    @(posedge clk); @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;

    // 1: basic group, drain at full rate, turnaround timing
    ready_mode = 0;
    send_beat(16'h8000, 8'sd3, 1'b0, 1'b0);
    send_beat(16'h8000, 8'sd5, 1'b0, 1'b0);
    send_beat(16'h0001, -8'sd2, 1'b0, 1'b0);
    send_beat(16'h0001, -8'sd2, 1'b1, 1'b0);
    check("out_valid_rise", out_valid, 1);
    check("first_drain_data", out_data, 8);
    n = 0;
    while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
    check("in_ready_turnaround", n, 16);
    check("t1_queue_empty", exp_q.size(), 0);

    // 2: multi-bit beat sets sticky error; zero one-hot changes nothing
    send_beat(16'h8001, 8'sd7, 1'b1, 1'b0);
    wait_drain();
    send_beat(16'h0000, 8'sd33, 1'b0, 1'b0);
    send_beat(16'h4000, 8'sd5, 1'b1, 1'b0);
    wait_drain();
    check("err_sticky", err_multi, 1);

    // 3: wrap on the 9-bit instance
    check("wrap_in_ready", w_in_ready, 1);
    w_in_onehot = 16'h8000; w_in_act = 8'sd127; w_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w_in_last = (i == 2);
      @(posedge clk); #1;
    end
    w_in_valid = 1'b0; w_in_last = 1'b0;
    check("wrap_out_valid", w_out_valid, 1);
    check("wrap_out_idx", w_out_idx, 0);
    check("wrap_out_data", w_out_data, -131);
    repeat (16) @(posedge clk);
    #1;
    check("wrap_in_ready_back", w_in_ready, 1);

    // 4: backpressure with ignored input pulses during drain
    ready_mode = 1; rdy_cnt = 0;
    rand_group(5);
    n = 0;
    while (n < 400) begin
      @(negedge clk); #2; n++;
      if (exp_q.size() == 0) begin in_valid = 1'b0; in_last = 1'b0; break; end
      in_valid  = 1'($urandom_range(0, 1));
      in_onehot = 16'($urandom);
      in_act    = ACT_W'($urandom);
      in_last   = 1'($urandom_range(0, 1));
    end
    check("t4_drain_done", exp_q.size(), 0);
    ready_mode = 2;
    rand_group(4);
    wait_drain();

    // 5: reset mid-drain at idx 6
    ready_mode = 0;
    rand_group(3);
    n = 0;
    while (n < 40) begin
      @(posedge clk); #2; n++;
      if (out_valid && out_idx == 4'd6) break;
    end
    check("reach_idx6", out_idx, 6);
    reset = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 16; k++) grp[k] = 0;
    exp_err = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_idx", out_idx, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_err_multi", err_multi, 0);
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #1;
    send_beat(16'h0400, -8'sd1, 1'b1, 1'b0);
    check("t5_bin0_zero", out_data, 0);
    wait_drain();

    // 6: back-to-back groups with in_valid held high
    ready_mode = 0;
    for (int g = 0; g < 4; g++)
      for (int i = 0; i < 3; i++)
        send_beat(rand_onehot(), ACT_W'($urandom), (i == 2), 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    wait_drain();

    // Random tail with random backpressure
    ready_mode = 2;
    for (int g = 0; g < 3; g++) begin
      rand_group($urandom_range(1, 6));
      wait_drain();
    end

    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
